spi_target: RTL
===============

SPI_TARGET -- requirements
Module: spi_target

Interface
REQ-001 The block SHALL have parameter SYNC_STAGES, default 2, giving the synchronizer depth for SCLK, MOSI and CS_N, with a legal range of 2..4.
REQ-002 The block SHALL have parameter FILL_BYTE, default 8'hFF, giving the byte shifted out when no transmit data is queued.
REQ-003 The block SHALL have port CLK, input, 1 bit: the single system clock.
REQ-004 The block SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port spi_sclk, input, 1 bit: external SPI clock, asynchronous to CLK.
REQ-006 The block SHALL have port spi_mosi, input, 1 bit: external serial data in.
REQ-007 The block SHALL have port spi_cs_n, input, 1 bit: external chip select, active low.
REQ-008 The block SHALL have port spi_miso, output, 1 bit: serial data out.
REQ-009 The block SHALL have port spi_miso_en, output, 1 bit: MISO output enable, high only while selected.
REQ-010 The block SHALL have port rx_valid, output, 1 bit: one-cycle strobe marking a completed received byte.
REQ-011 The block SHALL have port rx_data, output, 8 bits: the last complete received byte.
REQ-012 The block SHALL have port tx_valid, input, 1 bit: transmit byte offered.
REQ-013 The block SHALL have port tx_data, input, 8 bits: the transmit byte.
REQ-014 The block SHALL have port tx_ready, output, 1 bit: transmit holding register empty.
REQ-015 The block SHALL have port tx_underrun, output, 1 bit: one-cycle strobe, FILL_BYTE was loaded.
REQ-016 The block SHALL have port busy, output, 1 bit: high while in ACTIVE.

Function
REQ-017 SPI mode 0, MSB first, 8-bit bytes; SCLK frequency SHALL be at most CLK/8.
REQ-018 All edge and level decisions SHALL use the synchronized copies of spi_sclk, spi_mosi and spi_cs_n.
REQ-019 Edge detection SHALL compare the last two synchronized SCLK samples.
REQ-020 FSM states: IDLE -> ACTIVE when synchronized CS_N is low; ACTIVE -> IDLE when synchronized CS_N is high.
REQ-021 On IDLE->ACTIVE: bit counter := 0; the shift-out register is loaded (see REQ-025); spi_miso := bit 7; spi_miso_en := 1.
REQ-022 On an SCLK rising edge in ACTIVE: synchronized MOSI is shifted into bit 0 of the receive shift register, and the 3-bit counter increments, wrapping 7->0.
REQ-023 On the rising edge where the counter wraps 7->0: rx_data := the completed byte, and rx_valid is high for exactly the next CLK cycle, no later than SYNC_STAGES+2 CLK cycles after that SCLK edge on the pin.
REQ-024 On an SCLK falling edge in ACTIVE with counter != 0: the shift-out register shifts left and spi_miso := its new bit 7.
REQ-025 On an SCLK falling edge with counter == 0 (byte boundary), and on CS entry:
- if the holding register is full, it is loaded into the shift-out register and marked empty;
- otherwise FILL_BYTE is loaded and tx_underrun pulses for one cycle.
REQ-026 tx_ready SHALL equal NOT(holding register full); the transfer occurs when tx_valid && tx_ready.
REQ-027 If an acceptance and a REQ-025 load occur in the same cycle, the load SHALL use FILL_BYTE (or the prior contents) and the accepted byte SHALL remain queued for the next boundary.
REQ-028 rx has no backpressure; a byte not taken on rx_valid is lost, and rx_data holds its value until the next completed byte.
REQ-029 CS_N rising mid-byte SHALL abort the byte:
- the partial byte is discarded with no rx_valid;
- the counter is reset;
- spi_miso_en := 0 in the same cycle the state returns to IDLE;
- the holding register is preserved.
REQ-030 SCLK edges while in IDLE SHALL be ignored.

Reset
REQ-031 RST_N low SHALL asynchronously force:
- state IDLE; counter 0;
- rx_valid 0, rx_data 0, tx_underrun 0;
- spi_miso 1, spi_miso_en 0;
- holding register empty (tx_ready 1), busy 0;
- all synchronizer flops: CS_N 1, SCLK 0, MOSI 0.
REQ-032 Reset deassertion mid-transfer SHALL leave the block in IDLE until a fresh CS_N falling edge is seen; SCLK activity while CS_N stays low SHALL NOT start a byte.

Structure
REQ-033 A shared package spi_target_pkg SHALL hold the state enum (IDLE, ACTIVE), the byte-width constant (8) and the counter-width constant (3).
REQ-034 One sub-module, spi_sync, SHALL implement a SYNC_STAGES-deep flop synchronizer with a reset-value parameter, instantiated three times.

Verification
REQ-035 Preload tx 8'hA5, CS low, send MOSI 8'h3C at CLK/8 -> rx_valid pulses once with rx_data 8'h3C; MISO bits sampled at rising edges = A5.
REQ-036 Two back-to-back bytes with tx 8'h11 queued only before the first -> MISO 11 then FF; tx_underrun pulses once at the second boundary; rx_valid pulses twice.
REQ-037 CS high after 5 SCLK edges -> no rx_valid, spi_miso_en low, busy low; next full byte 8'h81 is received correctly.
REQ-038 Queue 8'h5A with tx_valid in the same cycle as a boundary load on empty -> that byte sends FF, next byte sends 5A.
REQ-039 RST_N asserted mid-byte and released with CS low -> all outputs at reset values; no rx_valid until a CS high-low cycle.
REQ-040 SYNC_STAGES=3, random 64-byte stream at CLK/8 -> received and transmitted streams match the scoreboard bit-exactly.

Source files
------------

// File: rtl/spi_target_pkg.sv
// Shared types and widths for the SPI target.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spi_target_pkg;

  localparam int BYTE_W = 8;
  localparam int CNT_W  = 3;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_e;

endpackage

// File: rtl/spi_sync.sv
// Multi-flop synchronizer for one asynchronous input bit.
// Latency: STAGES clock cycles from input to output.
// Backpressure: none; samples every cycle.
module spi_sync #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // Shift the raw input through the flop chain; reset to the idle level of the line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_target.sv
// SPI mode-0 target, MSB first, one-byte transmit holding register.
// Latency: rx_valid SYNC_STAGES+1 cycles after the 8th SCLK rise; MISO SYNC_STAGES+1 after SCLK fall.
// Backpressure: tx_ready low while holding register full; rx has none (unread bytes are lost).
module spi_target
  import spi_target_pkg::*;
#(
  parameter int unsigned       SYNC_STAGES = 2,
  parameter logic [BYTE_W-1:0] FILL_BYTE   = 8'hFF
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              spi_sclk,
  input  logic              spi_mosi,
  input  logic              spi_cs_n,
  output logic              spi_miso,
  output logic              spi_miso_en,
  output logic              rx_valid,
  output logic [BYTE_W-1:0] rx_data,
  input  logic              tx_valid,
  input  logic [BYTE_W-1:0] tx_data,
  output logic              tx_ready,
  output logic              tx_underrun,
  output logic              busy
);

  // Cycles after reset before the CS synchronizer holds a real pin sample.
  localparam logic [2:0] SETTLE_CNT = 3'(SYNC_STAGES);

  logic sclk_s, mosi_s, cs_n_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(spi_sclk), .q_o(sclk_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(spi_mosi), .q_o(mosi_s)
  );
  spi_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs (
    .clk_i(CLK), .rst_ni(RST_N), .d_i(spi_cs_n), .q_o(cs_n_s)
  );

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [BYTE_W-2:0] rx_shift_q;   // first seven bits of the byte in flight
  logic [BYTE_W-2:0] tx_shift_q;   // bits still to go out after the one on MISO
  logic [BYTE_W-1:0] rx_data_q;
  logic [BYTE_W-1:0] hold_q;
  logic              hold_full_q;
  logic              rx_valid_q, underrun_q, miso_q, miso_en_q;
  logic              sclk_prev_q;
  logic              armed_q;      // CS seen high since reset; a select must start from deselect
  logic [2:0]        settle_q;

  logic              sclk_rise, sclk_fall, cs_enter, byte_boundary, do_load;
  logic [BYTE_W-1:0] load_byte;

  assign sclk_rise     = sclk_s & ~sclk_prev_q;
  assign sclk_fall     = ~sclk_s & sclk_prev_q;
  assign cs_enter      = (state_q == IDLE) && !cs_n_s && armed_q;
  assign byte_boundary = (state_q == ACTIVE) && !cs_n_s && sclk_fall && (cnt_q == '0);
  assign do_load       = cs_enter || byte_boundary;
  // Load decision uses the holding register as it stood before this cycle's accept.
  assign load_byte     = hold_full_q ? hold_q : FILL_BYTE;

  // Main FSM: selection tracking, bit shifting, holding-register handshake, output strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      rx_data_q   <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      miso_q      <= 1'b1;
      miso_en_q   <= 1'b0;
      sclk_prev_q <= 1'b0;
      armed_q     <= 1'b0;
      settle_q    <= '0;
    end else begin
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      sclk_prev_q <= sclk_s;

      if (settle_q != SETTLE_CNT) settle_q <= settle_q + 3'd1;
      if ((settle_q == SETTLE_CNT) && cs_n_s) armed_q <= 1'b1;

      if (tx_valid && !hold_full_q) begin
        hold_q      <= tx_data;
        hold_full_q <= 1'b1;
      end

      if (do_load) begin
        tx_shift_q <= load_byte[BYTE_W-2:0];
        miso_q     <= load_byte[BYTE_W-1];
        if (hold_full_q) hold_full_q <= 1'b0;
        else             underrun_q  <= 1'b1;
      end

      case (state_q)
        IDLE: begin
          if (cs_enter) begin
            state_q   <= ACTIVE;
            cnt_q     <= '0;
            miso_en_q <= 1'b1;
          end
        end
        ACTIVE: begin
          if (cs_n_s) begin
            // Deselect aborts any partial byte; the holding register is left alone.
            state_q   <= IDLE;
            cnt_q     <= '0;
            miso_en_q <= 1'b0;
          end else if (sclk_rise) begin
            rx_shift_q <= {rx_shift_q[BYTE_W-3:0], mosi_s};
            cnt_q      <= cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(BYTE_W - 1)) begin
              rx_data_q  <= {rx_shift_q, mosi_s};
              rx_valid_q <= 1'b1;
            end
          end else if (sclk_fall && (cnt_q != '0)) begin
            miso_q     <= tx_shift_q[BYTE_W-2];
            tx_shift_q <= {tx_shift_q[BYTE_W-3:0], 1'b0};
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign spi_miso    = miso_q;
  assign spi_miso_en = miso_en_q;
  assign rx_valid    = rx_valid_q;
  assign rx_data     = rx_data_q;
  assign tx_ready    = !hold_full_q;
  assign tx_underrun = underrun_q;
  assign busy        = (state_q == ACTIVE);

endmodule
